// File: rtl/bcd_scan_ctrl.sv
// Run/pause/load controller for a cascaded BCD counter.
// Also scans a shared common-anode 7-segment decoder across the digits.
module bcd_scan_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 8,
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst_syn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  output logic [4*DIGITS-1:0]   count_out,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg_out,
  output logic                  running,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(DIGITS);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e              state_q;
  logic [TW-1:0]       tick_q;
  logic [SW-1:0]       scan_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_next;
  logic [4*DIGITS-1:0] count_inc;
  logic                data_valid;
  logic                all_nines;
  logic                carry;
  logic                tick_last;
  logic [3:0]          nibble;

  // Ripple carry across digits so the whole number steps in one edge.
  always_comb begin
    data_valid = 1'b1;
    all_nines  = 1'b1;
    count_inc  = count_out;
    carry      = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (data[4*i +: 4] > 4'd9) data_valid = 1'b0;
      if (count_out[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (count_out[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_out[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  assign tick_last = (tick_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_syn) begin
      state_q   <= StIdle;
      running   <= 1'b0;
      count_out <= '0;
      tick_q    <= '0;
      wrap      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        // A rejected load leaves state, count and prescaler untouched.
        if (data_valid) begin
          count_out <= data;
          state_q   <= StPause;
          running   <= 1'b0;
          tick_q    <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (stop) begin
        if (state_q == StRun) begin
          state_q <= StPause;
          running <= 1'b0;
        end
      end else if (start && state_q != StRun) begin
        state_q <= StRun;
        running <= 1'b1;
        tick_q  <= '0;
      end else if (state_q == StRun) begin
        if (tick_last) begin
          tick_q    <= '0;
          count_out <= count_inc;
          wrap      <= all_nines;
        end else begin
          tick_q <= tick_q + TW'(1);
        end
      end
    end
  end

  assign idx_next = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

  always_ff @(posedge clk) begin
    if (!rst_syn) begin
      scan_q <= '0;
      idx_q  <= '0;
      an     <= ~DIGITS'(1);
    end else if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      idx_q  <= idx_next;
      an     <= ~(DIGITS'(1) << idx_next);
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

  assign nibble = count_out[{idx_q, 2'b00} +: 4];

  always_comb begin
    seg_out = 8'hFF;
    case (nibble)
      4'd0:    seg_out = 8'hC0;
      4'd1:    seg_out = 8'hF9;
      4'd2:    seg_out = 8'hA4;
      4'd3:    seg_out = 8'hB0;
      4'd4:    seg_out = 8'h99;
      4'd5:    seg_out = 8'h92;
      4'd6:    seg_out = 8'h82;
      4'd7:    seg_out = 8'hF8;
      4'd8:    seg_out = 8'h80;
      4'd9:    seg_out = 8'h90;
      default: seg_out = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Self-checking bench for bcd_scan_ctrl: vector table through a scoreboard queue,
// hand-written reset sequences, and a background display checker.
module tb_bcd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_syn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] count_out;
  logic [3:0]  an;
  logic [7:0]  seg_out;
  logic        running;
  logic        wrap;
  logic        load_err;

  int n_vec  = 0;
  int n_miss = 0;
  bit bg_en  = 1'b0;

  logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic        sp;
    logic [15:0] d;
    int          idle;
    logic [15:0] e_cnt;
    logic        e_run;
    logic        e_wrap;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  bcd_scan_ctrl #(.DIGITS(4), .TICK_DIV(8), .SCAN_DIV(16)) dut (
    .clk       (clk),
    .rst_syn   (rst_syn),
    .start     (start),
    .stop      (stop),
    .load      (load),
    .data      (data),
    .count_out (count_out),
    .an        (an),
    .seg_out   (seg_out),
    .running   (running),
    .wrap      (wrap),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Display must always show exactly one digit, decoded from the selected nibble.
  always @(negedge clk) begin
    int sel;
    logic [3:0] nib;
    logic [7:0] exp_seg;
    if (bg_en) begin
      sel = -1;
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) sel = i;
      check("an_onecold", 16'($countones(~an)), 16'd1);
      if (sel >= 0) begin
        nib     = count_out[sel*4 +: 4];
        exp_seg = (nib <= 4'd9) ? seg_tab[nib] : 8'hFF;
        check("seg_decode", {8'h00, seg_out}, {8'h00, exp_seg});
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    load  = v.ld;
    start = v.st;
    stop  = v.sp;
    data  = v.d;
    exp_q.push_back(v);
    edge1();
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    data  = '0;
    repeat (v.idle) edge1();
    e = exp_q.pop_front();
    check({e.name, ".count"}, count_out, e.e_cnt);
    check({e.name, ".running"}, {15'd0, running}, {15'd0, e.e_run});
    check({e.name, ".wrap"}, {15'd0, wrap}, {15'd0, e.e_wrap});
    check({e.name, ".load_err"}, {15'd0, load_err}, {15'd0, e.e_err});
  endtask

  initial begin
    vecs.push_back('{"ld97",    1, 0, 0, 16'h0097, 0, 16'h0097, 0, 0, 0});
    vecs.push_back('{"st1",     0, 1, 0, 16'h0000, 0, 16'h0097, 1, 0, 0});
    vecs.push_back('{"w7a",     0, 0, 0, 16'h0000, 6, 16'h0097, 1, 0, 0});
    vecs.push_back('{"inc98",   0, 0, 0, 16'h0000, 0, 16'h0098, 1, 0, 0});
    vecs.push_back('{"w7b",     0, 0, 0, 16'h0000, 6, 16'h0098, 1, 0, 0});
    vecs.push_back('{"inc99",   0, 0, 0, 16'h0000, 0, 16'h0099, 1, 0, 0});
    vecs.push_back('{"inc100",  0, 0, 0, 16'h0000, 7, 16'h0100, 1, 0, 0});
    vecs.push_back('{"ld9999",  1, 0, 0, 16'h9999, 0, 16'h9999, 0, 0, 0});
    vecs.push_back('{"st2",     0, 1, 0, 16'h0000, 0, 16'h9999, 1, 0, 0});
    vecs.push_back('{"w7c",     0, 0, 0, 16'h0000, 6, 16'h9999, 1, 0, 0});
    vecs.push_back('{"roll",    0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0});
    vecs.push_back('{"postroll",0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0});
    vecs.push_back('{"ld42",    1, 0, 0, 16'h0042, 0, 16'h0042, 0, 0, 0});
    vecs.push_back('{"bad_p",   1, 0, 0, 16'h12A4, 0, 16'h0042, 0, 0, 1});
    vecs.push_back('{"bad_clr", 0, 0, 0, 16'h0000, 0, 16'h0042, 0, 0, 0});
    vecs.push_back('{"st3",     0, 1, 0, 16'h0000, 0, 16'h0042, 1, 0, 0});
    vecs.push_back('{"bad_r",   1, 0, 0, 16'h12A4, 0, 16'h0042, 1, 0, 1});
    vecs.push_back('{"sp1",     0, 0, 1, 16'h0000, 0, 16'h0042, 0, 0, 0});
    vecs.push_back('{"st4",     0, 1, 0, 16'h0000, 0, 16'h0042, 1, 0, 0});
    vecs.push_back('{"w7d",     0, 0, 0, 16'h0000, 6, 16'h0042, 1, 0, 0});
    vecs.push_back('{"collide", 1, 1, 1, 16'h0005, 0, 16'h0005, 0, 0, 0});
    vecs.push_back('{"st5",     0, 1, 0, 16'h0000, 0, 16'h0005, 1, 0, 0});
    vecs.push_back('{"w7e",     0, 0, 0, 16'h0000, 6, 16'h0005, 1, 0, 0});
    vecs.push_back('{"inc6",    0, 0, 0, 16'h0000, 0, 16'h0006, 1, 0, 0});
    vecs.push_back('{"w7f",     0, 0, 0, 16'h0000, 6, 16'h0006, 1, 0, 0});
    vecs.push_back('{"sp_tick", 0, 0, 1, 16'h0000, 0, 16'h0006, 0, 0, 0});
    vecs.push_back('{"hold",    0, 0, 0, 16'h0000, 10, 16'h0006, 0, 0, 0});
    vecs.push_back('{"st6",     0, 1, 0, 16'h0000, 0, 16'h0006, 1, 0, 0});
    vecs.push_back('{"st_run",  0, 1, 0, 16'h0000, 5, 16'h0006, 1, 0, 0});
    vecs.push_back('{"w7g",     0, 0, 0, 16'h0000, 0, 16'h0006, 1, 0, 0});
    vecs.push_back('{"inc7",    0, 0, 0, 16'h0000, 0, 16'h0007, 1, 0, 0});

    // Reset then idle: scan walks the digits with the count held at zero.
    rst_syn = 1'b0;
    repeat (2) edge1();
    bg_en = 1'b1;
    check("rst.count", count_out, 16'h0000);
    check("rst.running", {15'd0, running}, 16'd0);
    check("rst.wrap", {15'd0, wrap}, 16'd0);
    check("rst.load_err", {15'd0, load_err}, 16'd0);
    check("rst.an", {12'd0, an}, 16'h000E);
    check("rst.seg", {8'd0, seg_out}, 16'h00C0);
    rst_syn = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      logic [3:0] exp_an;
      edge1();
      exp_an = ~(4'b0001 << ((i / 16) % 4));
      check("idle.an", {12'd0, an}, {12'd0, exp_an});
      check("idle.count", count_out, 16'h0000);
      check("idle.running", {15'd0, running}, 16'd0);
      check("idle.seg", {8'd0, seg_out}, 16'h00C0);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-run with start held: reset wins, then start is taken again.
    load = 1'b1;
    data = 16'h0123;
    edge1();
    load  = 1'b0;
    data  = '0;
    start = 1'b1;
    repeat (4) edge1();
    check("mid.count", count_out, 16'h0123);
    check("mid.running", {15'd0, running}, 16'd1);
    rst_syn = 1'b0;
    edge1();
    check("mrst.count", count_out, 16'h0000);
    check("mrst.running", {15'd0, running}, 16'd0);
    check("mrst.an", {12'd0, an}, 16'h000E);
    check("mrst.seg", {8'd0, seg_out}, 16'h00C0);
    rst_syn = 1'b1;
    edge1();
    check("mrst.restart", {15'd0, running}, 16'd1);
    repeat (7) edge1();
    check("mrst.w7", count_out, 16'h0000);
    edge1();
    check("mrst.inc1", count_out, 16'h0001);
    start = 1'b0;
    repeat (3) edge1();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
- Run/pause/load controller for a cascaded multi-digit BCD counter. Each digit counts 0-9, with carry ripple between digits.
- Time-multiplexes one shared common-anode 7-segment decoder across all digits, using active-low digit enables.
- Sits between front-panel controls (start/stop/load buttons and a data switch bank) and the display pins.

Parameters:
- DIGITS, 4, number of BCD digits. Legal range 2-8.
- TICK_DIV, 8, clock cycles per count increment while running. Minimum 2.
- SCAN_DIV, 16, clock cycles each digit stays selected on the display. Minimum 2.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst_syn  in  1  synchronous, active-low reset.
- start  in  1  level input: requests the RUN state.
- stop  in  1  level input: requests the PAUSE state.
- load  in  1  level input: requests a load of data.
- data  in  4*DIGITS  BCD load value. Nibble 0 is the least significant digit.
- count_out  out  4*DIGITS  current BCD count, registered.
- an  out  DIGITS  digit enables, active low, one-cold.
- seg_out  out  8  common-anode segment code for the selected digit. Bit 7 is dp, held off (1).
- running  out  1  high while in RUN.
- wrap  out  1  one-cycle pulse on the all-9s to all-0s rollover.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Clock and reset: single clock clk. Reset rst_syn is synchronous and active low; it is sampled only on the clk rising edge.
- Reset values (rst_syn=0 at an edge):
  - state=IDLE, count_out=0, running=0, wrap=0, load_err=0.
  - Scan index=0, an=~1 (4'b1110 for DIGITS=4), seg_out=8'hC0.
  - Tick and scan prescalers cleared.
  - Reset mid-run or mid-scan overrides every other input in that cycle.
- FSM states: IDLE, RUN, PAUSE.
- Command priority within one cycle: load > stop > start.
- load:
  - Valid only if every data nibble is <= 9.
  - If valid: count_out <= data at that edge, state -> PAUSE (from any state), tick prescaler cleared.
  - If any nibble is > 9: count_out and state are unchanged, and load_err pulses high for exactly one cycle (the cycle after the edge).
  - Holding load high reloads on every cycle. An invalid load that is held produces a load_err pulse on every cycle.
- stop: RUN -> PAUSE. Ignored in IDLE and PAUSE.
- start: IDLE or PAUSE -> RUN, and the tick prescaler is cleared on entry. Ignored in RUN.
- running = (state==RUN), registered with the state.
- Counting:
  - The tick prescaler advances only in RUN and is held in IDLE and PAUSE.
  - When the prescaler reaches TICK_DIV-1 it returns to 0 and the count increments at that same edge.
  - First increment: if start is accepted at edge k, count_out changes at edge k+TICK_DIV, then every TICK_DIV cycles after that.
  - Increment rule: digit 0 adds 1. A digit at 9 goes to 0 and carries into the next digit. Carry is evaluated combinationally within the cycle, so the whole number updates in one edge.
  - Rollover: all digits at 9 -> all 0, with wrap=1 for that one cycle. Counting continues; the state stays RUN.
  - Non-BCD digit values cannot arise, because loads are validated.
- Simultaneous events: a stop or load in the same cycle as a tick edge wins. There is no increment on that edge, and the loaded value is not incremented.
- Display scan:
  - Runs in every state, independent of the FSM.
  - The scan prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 the scan index advances, wrapping from DIGITS-1 to 0.
  - an is registered: an = ~(1 << index).
  - seg_out is a combinational decode of the count_out nibble at the current index, so a count change is visible in the same cycle count_out changes.
- Decode (common-anode, active-low segments): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, any other value=FF.
- Exactly one an bit is low at all times after reset.

Test Plan:
1. Reset then idle: hold rst_syn=0 for 2 cycles, release, run 100 cycles.
   - count_out=0 and running=0 throughout.
   - an cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, 16 cycles per step.
   - seg_out=C0 throughout.
2. Load then run: load data=16'h0097 (a valid load moves the state to PAUSE), then start.
   - The first increment lands TICK_DIV (8) cycles after the start edge.
   - count_out goes 0098, then 0099, then 0100. Each of these changes happens 8 cycles after the previous one.
   - running=1 from the start edge onward.
3. Rollover: load 16'h9999, start.
   - After 8 cycles, count_out=0000, wrap is high for exactly 1 cycle, and running stays 1.
4. Invalid load: from count 0042, load 16'h12A4.
   - count_out stays 0042, state is unchanged, and load_err is high for 1 cycle.
5. Priority and collision: with start, stop and load=16'h0005 all high in one cycle while in RUN, at the tick edge:
   - count_out=0005, state=PAUSE, no increment.
   - A following start alone gives RUN, and 0006 appears 8 cycles later.
6. Reset mid-run: assert rst_syn=0 for one cycle at count 0123 with start held high.
   - Next cycle: count_out=0, state=IDLE, an=1110.
   - Next cycle: start (still held) is accepted again.
